// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the shared 8-digit seven-segment display.
// Each owner keeps the display for a minimum hold time, and one blank cycle separates owners.
module seg_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CLOCKS = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [32*NREQ-1:0]      data_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic [31:0]             data_o,
  output logic                    blank_o,
  output logic                    new_o
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(HOLD_CLOCKS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CLOCKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_SWITCH
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [31:0]       data_q, data_d;
  logic              blank_q, blank_d;
  logic              new_q, new_d;

  logic [31:0]       slices [NREQ];
  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  int                sum;

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign slices[k] = data_i[32*k +: 32];
  end

  // Search starts at ptr and wraps, so the most recent owner is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    sum    = 0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      cand = IDX_W'(sum);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    data_d  = data_q;
    blank_d = blank_q;
    new_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (found) begin
          state_d = ST_OWN;
          owner_d = winner;
          gnt_d   = NREQ'(1) << winner;
          data_d  = slices[winner];
          cnt_d   = '0;
          ptr_d   = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
          new_d   = 1'b1;
          blank_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          data_d  = '0;
          blank_d = 1'b1;
        end
      end
      ST_OWN: begin
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        data_d = slices[owner_q];
        // Release is honoured at any time; preemption only once the hold time has elapsed.
        if (!req_i[owner_q] || ((cnt_q == CNT_MAX) && |(req_i & ~gnt_q))) begin
          state_d = ST_SWITCH;
          gnt_d   = '0;
          data_d  = '0;
          blank_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        data_d  = '0;
        blank_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      blank_q <= 1'b1;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      new_q   <= new_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign data_o  = data_q;
  assign blank_o = blank_q;
  assign new_o   = new_q;

endmodule
